// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC accumulator datapath.
package mac_pkg;

    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DONE
    } acc_state_t;

endpackage

// File: rtl/acc_adder.sv
// ACC_W-bit unsigned add with carry-out; carry-in is always zero for accumulation.
module acc_adder #(
    parameter int ACC_W = 40
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             cout
);

    cla_nbit #(.n(ACC_W)) u_cla (
        .a    (a),
        .b    (b),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

endmodule

// File: rtl/cla_nbit.sv
// Generic n-bit adder with carry-in/carry-out built from generate/propagate terms.
module cla_nbit #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout
);

    logic [n-1:0] g;
    logic [n-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < n; i++) begin
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/mac_acc_stage.sv
// Accumulates 32-bit products into a wide sum and holds the result until accepted.
// Define ACC_SAT_EN to saturate the sum on carry-out instead of wrapping.
module mac_acc_stage
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [ACC_W-1:0] add_sum;
    logic             add_cout;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             beat;

    acc_adder #(.ACC_W(ACC_W)) u_add (
        .a    (acc),
        .b    ({{(ACC_W-32){1'b0}}, in_prod}),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef ACC_SAT_EN
    // Once pinned at all-ones, any non-zero product carries out again, so it stays pinned.
    assign acc_next = add_cout ? {ACC_W{1'b1}} : add_sum;
`else
    assign acc_next = add_sum;
`endif

    assign cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    // All handshake outputs decode registered state only.
    assign in_ready  = (state != ST_DONE);
    assign out_valid = (state == ST_DONE);
    assign beat      = in_valid && in_ready;

    assign out_acc = acc;
    assign out_cnt = cnt;
    assign out_ovf = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (in_clear) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ACC: begin
                    if (beat) begin
                        acc   <= acc_next;
                        cnt   <= cnt_next;
                        ovf   <= ovf | add_cout;
                        state <= in_last ? ST_DONE : ST_ACC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
